// File: rtl/retire_trace_monitor.sv
// Retire-event monitor: classifies writeback retires, buffers packed trace records in a FIFO,
// keeps cycle/instruction counters, a watchdog and halt-drain sequencing.
// Optional build macro TRACE_CYCLE_STAMP_EN appends a cycle stamp field to each record.
//
// Handshake: rec_valid/rec_ready follow strict valid/ready semantics. A record transfers on a
// rising edge where both are high; while rec_valid is high and rec_ready is low, rec_data and
// rec_valid hold steady, and rec_valid never drops without a transfer.
module retire_trace_monitor #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int RW      = 4,
  parameter int CW      = 32,
  parameter int DEPTH   = 16,
  parameter int MAX_CYC = 100000,
`ifdef TRACE_CYCLE_STAMP_EN
  localparam int STAMP_W = CW,
`else
  localparam int STAMP_W = 0,
`endif
  localparam int REC_W  = 2 + 2*AW + RW + DW + STAMP_W,
  localparam int PW     = $clog2(DEPTH),
  localparam int LW     = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ret_valid,
  input  logic [AW-1:0]    ret_pc,
  input  logic             ret_regwrite,
  input  logic [RW-1:0]    ret_wreg,
  input  logic [DW-1:0]    ret_wdata,
  input  logic             ret_memread,
  input  logic             ret_memwrite,
  input  logic [AW-1:0]    ret_maddr,
  input  logic [DW-1:0]    ret_mdata,
  input  logic             ret_halt,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [REC_W-1:0] rec_data,
  output logic [LW-1:0]    fifo_level,
  output logic [CW-1:0]    cycle_count,
  output logic [CW-1:0]    inst_count,
  output logic             overflow,
  output logic             timeout,
  output logic             done,
  output logic [1:0]       dbgState
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } stateT;

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [CW-1:0] WD_LAST    = CW'(MAX_CYC - 1);

  stateT            state;
  stateT            stateNext;

  logic [REC_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [LW-1:0]    level;

  logic             inRun;
  logic             counting;
  logic             pushReq;
  logic             pushOk;
  logic             pop;
  logic             full;

  logic [1:0]       recKind;
  logic [RW-1:0]    recWreg;
  logic [DW-1:0]    recValue;
  logic [AW-1:0]    recAddr;
  logic [REC_W-1:0] newRec;

  assign inRun    = (state == ST_RUN);
  assign counting = (state == ST_RUN) || (state == ST_DRAIN);
  assign full     = (level == FULL_LEVEL);
  assign pop      = rec_valid && rec_ready;
  assign pushReq  = inRun && ret_valid;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pushOk   = pushReq && (!full || pop);

  // Record classification: halt > store > register write > other.
  always_comb begin
    recKind  = 2'd0;
    recWreg  = '0;
    recValue = '0;
    recAddr  = '0;
    if (ret_halt) begin
      recKind = 2'd3;
    end else if (ret_memwrite) begin
      recKind  = 2'd2;
      recValue = ret_mdata;
      recAddr  = ret_maddr;
    end else if (ret_regwrite) begin
      recKind  = 2'd1;
      recWreg  = ret_wreg;
      recValue = ret_wdata;
      recAddr  = ret_memread ? ret_maddr : '0;
    end
  end

`ifdef TRACE_CYCLE_STAMP_EN
  assign newRec = {recKind, ret_pc, recWreg, recValue, recAddr, cycle_count};
`else
  assign newRec = {recKind, ret_pc, recWreg, recValue, recAddr};
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= stateNext;
    end
  end

  // FSM: next state; a halt retire takes priority over the watchdog in the same cycle.
  always_comb begin
    stateNext = state;
    case (state)
      ST_RUN: begin
        if (ret_valid && ret_halt) begin
          stateNext = ST_DRAIN;
        end else if (cycle_count == WD_LAST) begin
          stateNext = ST_TIMEOUT;
        end
      end
      ST_DRAIN: begin
        if (level == '0) begin
          stateNext = ST_DONE;
        end
      end
      default: stateNext = state;
    endcase
  end

  assign done     = (state == ST_DONE);
  assign timeout  = (state == ST_TIMEOUT);
  assign dbgState = state;

  // Counters and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_count <= '0;
      inst_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (counting && (cycle_count != '1)) begin
        cycle_count <= cycle_count + 1'b1;
      end
      // Dropped records still count as retired instructions.
      if (pushReq && (inst_count != '1)) begin
        inst_count <= inst_count + 1'b1;
      end
      if (pushReq && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are left unreset, the pointers define what is live.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem[wrPtr] <= newRec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (pushOk) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({pushOk, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign fifo_level = level;
  assign rec_valid  = (level != '0);
  assign rec_data   = rec_valid ? mem[rdPtr] : '0;

endmodule
